// File: rtl/arm_prog_loader.sv
// Program loader: packs a little-endian host byte stream into 32-bit words,
// writes them to program memory, then releases the core and supervises it
// until it halts, times out, or the load overflows the memory.
module arm_prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  input  logic        halted,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_write_en,
  output logic        core_rst,
  output logic [2:0]  state,
  output logic [15:0] word_count,
  output logic [31:0] run_cycles,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_HALTED = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_idx;
  logic [31:0] r_asm;
  logic        r_fin;
  logic [15:0] r_wc;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_run;
  logic        r_done;
  logic        r_err;

  logic        w_in_ready;
  logic        w_start;
  logic        w_accept;
  logic        w_overflow;
  logic        w_byte_ok;
  logic        w_word_done;
  logic        w_timeout;
  logic [31:0] w_word;

  assign w_start     = load_start &&
                       (r_state == S_IDLE || r_state == S_HALTED || r_state == S_ERROR);
  assign w_accept    = in_valid && w_in_ready;
  assign w_overflow  = w_accept && (32'(r_wc) == MEM_WORDS);
  assign w_byte_ok   = w_accept && !w_overflow;
  assign w_word_done = w_byte_ok && (r_idx == 2'd3 || in_last);
  // Assembly register only ever holds filled bytes, so a partial word is zero-padded.
  assign w_word      = r_asm | (32'(in_byte) << {r_idx, 3'b000});
  assign w_timeout   = (TIMEOUT != 0) && (r_run == TIMEOUT);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_HALTED, S_ERROR: if (load_start) w_next = S_LOAD;
      S_LOAD: begin
        // r_fin marks the cycle carrying the final write; leave only after it.
        if (r_fin)           w_next = S_RUN;
        else if (w_overflow) w_next = S_ERROR;
      end
      S_RUN: begin
        if (halted)         w_next = S_HALTED;
        else if (w_timeout) w_next = S_ERROR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_in_ready = (r_state == S_LOAD) && !r_fin;
    core_rst   = (r_state != S_RUN);
  end

  // Byte assembly and memory write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx  <= '0;
      r_asm  <= '0;
      r_fin  <= 1'b0;
      r_wc   <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_word_done;
      if (w_start) begin
        r_idx <= '0;
        r_asm <= '0;
        r_fin <= 1'b0;
        r_wc  <= '0;
      end else if (w_word_done) begin
        r_addr <= BASE_ADDR + {14'b0, r_wc, 2'b00};
        r_data <= w_word;
        r_wc   <= r_wc + 16'd1;
        r_idx  <= '0;
        r_asm  <= '0;
        r_fin  <= in_last;
      end else if (w_byte_ok) begin
        r_asm <= w_word;
        r_idx <= r_idx + 2'd1;
      end else if (r_fin) begin
        r_fin <= 1'b0;
      end
    end
  end

  // Run-cycle counter and sticky status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_start) begin
      r_run  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_RUN && !halted && r_run != '1) r_run <= r_run + 32'd1;
      if (r_state == S_RUN && halted) r_done <= 1'b1;
      if (w_overflow || (r_state == S_RUN && !halted && w_timeout)) r_err <= 1'b1;
    end
  end

  assign in_ready     = w_in_ready;
  assign mem_write_en = r_we;
  assign mem_addr     = r_addr;
  assign mem_data_in  = r_data;
  assign state        = r_state;
  assign word_count   = r_wc;
  assign run_cycles   = r_run;
  assign done         = r_done;
  assign error        = r_err;

endmodule

// File: tb/tb_arm_prog_loader.sv
// Bench for arm_prog_loader: transaction-level reference model compared on
// every cycle, directed scenarios with literal expectations, then random loads.
module tb_arm_prog_loader;

  localparam int unsigned MW = 2;
  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = '0;
  logic        in_last = 1'b0;
  logic        halted = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_write_en;
  logic        core_rst;
  logic [2:0]  state;
  logic [15:0] word_count;
  logic [31:0] run_cycles;
  logic        done;
  logic        error;

  arm_prog_loader #(.BASE_ADDR(32'h0), .MEM_WORDS(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_last(in_last),
    .halted(halted), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .core_rst(core_rst), .state(state),
    .word_count(word_count), .run_cycles(run_cycles), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 60)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 loading, 2 running, 3 halted, 4 error.
  int          m_phase = 0;
  bit          m_final = 0;   // final word has been written, core not yet released
  logic [7:0]  m_bytes[$];
  int unsigned m_wc = 0;
  logic [31:0] m_run = 0;
  bit          m_done = 0, m_err = 0, m_we = 0;
  logic [31:0] m_addr = 0, m_data = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_final = 0; m_bytes.delete(); m_wc = 0; m_run = 0;
      m_done = 0; m_err = 0; m_we = 0; m_addr = 0; m_data = 0;
    end else begin
      logic [31:0] w;
      logic [31:0] old_run;
      m_we = 0;
      case (m_phase)
        0, 3, 4: if (load_start) begin
          m_phase = 1; m_final = 0; m_bytes.delete();
          m_wc = 0; m_run = 0; m_done = 0; m_err = 0;
        end
        1: begin
          if (m_final) begin
            m_phase = 2; m_final = 0;
          end else if (in_valid) begin
            if (m_wc == MW) begin
              m_phase = 4; m_err = 1;
            end else begin
              m_bytes.push_back(in_byte);
              if (m_bytes.size() == 4 || in_last) begin
                w = 0;
                foreach (m_bytes[k]) w = w + (32'(m_bytes[k]) * (32'd1 << (8 * k)));
                m_we = 1; m_addr = 4 * m_wc; m_data = w; m_wc++;
                m_bytes.delete();
                if (in_last) m_final = 1;
              end
            end
          end
        end
        2: begin
          old_run = m_run;
          if (halted) begin
            m_phase = 3; m_done = 1;
          end else begin
            if (m_run != 32'hFFFF_FFFF) m_run = m_run + 1;
            if (old_run == TO) begin m_phase = 4; m_err = 1; end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  always @(negedge clk) begin
    chk("state",        32'(state),        32'(m_phase));
    chk("in_ready",     32'(in_ready),     32'(m_phase == 1 && !m_final));
    chk("core_rst",     32'(core_rst),     32'(m_phase != 2));
    chk("mem_write_en", 32'(mem_write_en), 32'(m_we));
    chk("mem_addr",     mem_addr,          m_addr);
    chk("mem_data_in",  mem_data_in,       m_data);
    chk("word_count",   32'(word_count),   m_wc);
    chk("run_cycles",   run_cycles,        m_run);
    chk("done",         32'(done),         32'(m_done));
    chk("error",        32'(error),        32'(m_err));
    if (mem_write_en === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_data_in);
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  int stalls = 0;

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Present one byte; returns at the falling edge after it was accepted.
  task automatic send_byte(input logic [7:0] b, input bit last);
    int n = 0;
    in_valid = 1'b1; in_byte = b; in_last = last;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      n++; stalls++;
      if (n > 40) begin
        n_chk++; n_fail++;
        $display("FAIL in_ready_wait: got stalled %0d cycles expected accept", n);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic halt_now();
    halted = 1'b1;
    @(negedge clk);
    halted = 1'b0;
  endtask

  initial begin
    logic [7:0] b4[4];
    int len, k;
    bit lst;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: single full word
    pulse_start();
    b4 = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 4; i++) send_byte(b4[i], i == 3);
    chk("t1_we", 32'(mem_write_en), 32'd1);
    chk("t1_addr", mem_addr, 32'h0);
    chk("t1_data", mem_data_in, 32'h1234_5678);
    chk("t1_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t1_state_run", 32'(state), 32'd2);
    chk("t1_core_rst", 32'(core_rst), 32'd0);
    chk("t1_we_off", 32'(mem_write_en), 32'd0);

    // 4: halt after 10 running cycles
    repeat (10) @(negedge clk);
    halt_now();
    chk("t4_state", 32'(state), 32'd3);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_run_cycles", run_cycles, 32'd10);
    chk("t4_core_rst", 32'(core_rst), 32'd1);

    // 2: six bytes back-to-back, partial second word
    log_addr.delete(); log_data.delete(); stalls = 0;
    pulse_start();
    for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6);
    @(negedge clk);
    chk("t2_stalls", 32'(stalls), 32'd0);
    chk("t2_nwrites", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      chk("t2_addr0", log_addr[0], 32'h0);
      chk("t2_data0", log_data[0], 32'h0403_0201);
      chk("t2_addr1", log_addr[1], 32'h4);
      chk("t2_data1", log_data[1], 32'h0000_0605);
    end
    chk("t2_word_count", 32'(word_count), 32'd2);
    halt_now();

    // 3: overflow on ninth byte with two-word memory
    log_addr.delete(); log_data.delete();
    pulse_start();
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0);
    chk("t3_state", 32'(state), 32'd4);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_core_rst", 32'(core_rst), 32'd1);
    @(negedge clk);
    chk("t3_nwrites", 32'(log_addr.size()), 32'd2);
    chk("t3_last_data", mem_data_in, 32'h0807_0605);
    chk("t3_last_addr", mem_addr, 32'h4);

    // 5a: watchdog trips with halted held low
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'(i + 8'h10), i == 3);
    @(negedge clk);
    repeat (21) @(negedge clk);
    chk("t5a_state", 32'(state), 32'd4);
    chk("t5a_error", 32'(error), 32'd1);
    chk("t5a_core_rst", 32'(core_rst), 32'd1);

    // 5b: halted in the timeout cycle wins
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'(i + 8'h20), i == 3);
    @(negedge clk);
    repeat (20) @(negedge clk);
    halt_now();
    chk("t5b_state", 32'(state), 32'd3);
    chk("t5b_error", 32'(error), 32'd0);
    chk("t5b_done", 32'(done), 32'd1);
    chk("t5b_run_cycles", run_cycles, 32'd20);

    // 6: asynchronous reset mid-word, then clean reload
    pulse_start();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_core_rst", 32'(core_rst), 32'd1);
    chk("t6_we", 32'(mem_write_en), 32'd0);
    chk("t6_addr", mem_addr, 32'h0);
    chk("t6_data", mem_data_in, 32'h0);
    chk("t6_wc", 32'(word_count), 32'd0);
    chk("t6_done_err", 32'({done, error, in_ready}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_start();
    b4 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 4; i++) send_byte(b4[i], i == 3);
    chk("t6_reload_we", 32'(mem_write_en), 32'd1);
    chk("t6_reload_addr", mem_addr, 32'h0);
    chk("t6_reload_data", mem_data_in, 32'hDDCC_BBAA);
    @(negedge clk);
    halt_now();

    // random loads, gaps, ignored load_start pulses, run lengths around the watchdog
    for (int it = 0; it < 40; it++) begin
      pulse_start();
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        load_start = ($urandom_range(0, 7) == 0);
        halted     = $urandom_range(0, 1);
        lst = (i == len - 1) && (len <= 8 || $urandom_range(0, 1) == 1);
        send_byte(8'($urandom), lst);
        load_start = 1'b0;
      end
      halted = 1'b0;
      if (len <= 8) begin
        @(negedge clk);
        k = $urandom_range(0, 24);
        repeat (k) @(negedge clk);
        halt_now();
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected end of test");
    $fatal(1, "simulation time limit");
  end

endmodule
